div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative radix-2 divider for DIV/DIVU in the execute stage.
- Sits beside the ALU. It is started by the execute-stage ALU control decode of a divide, and it drives the divide stall that the hazard unit folds into stallE and the earlier-stage stalls.
- Produces {HI=remainder, LO=quotient} for the HI/LO write path, with one-pulse completion.
- Multi-cycle FSM holds the pipeline while dividing. It is cancelled by exception/flush.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start_i  in  1  a divide instruction is valid in execute (not flushed).
- signed_i  in  1  1=DIV, 0=DIVU; sampled with start_i.
- a_i  in  WIDTH  dividend (rs), sampled with start_i.
- b_i  in  WIDTH  divisor (rt), sampled with start_i.
- annul_i  in  1  abort the current operation (exception/flushE).
- stall_o  out  1  hold the pipeline (stall_divE).
- valid_o  out  1  one-cycle pulse: result_o is valid and the HI/LO write is allowed.
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, valid_o=0, result_o=0. stall_o=0 while in reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - With start_i=1 and annul_i=0: latch |a|, |b| and the sign flags. For DIVU, magnitudes are the raw values. Clear the partial remainder, then go to BUSY with count=0.
  - stall_o = start_i & ~annul_i, combinational in the start cycle.
- BUSY:
  - Performs one restoring step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - count increments each cycle. After step WIDTH-1 (count==WIDTH-1), go to DONE.
  - stall_o=1 for the whole state.
- DONE:
  - valid_o=1 and stall_o=0 for exactly one cycle; always returns to IDLE.
  - start_i is ignored here, because the same instruction is still in execute this cycle. This prevents a double start.
- Latency:
  - Start accepted in cycle 0; BUSY occupies cycles 1..WIDTH; DONE is cycle WIDTH+1 (cycle 33 at the default WIDTH).
  - stall_o is high for cycles 0..WIDTH (33 cycles at the default WIDTH).
- result_o:
  - Registered on entry to DONE; holds until the next DONE or reset.
  - Sign fix-up for DIV: quotient is negated if sign(a)!=sign(b); remainder takes the sign of a.
- Divide by zero (b==0, either mode): the full latency is still used. Result is Q={WIDTH{1}}, R=a_i (raw), with no sign fix-up.
- Signed overflow (0x80000000 / 0xFFFFFFFF): Q=0x80000000, R=0. This falls out of the magnitude math and must not trap.
- annul_i:
  - In any state: go to IDLE next cycle; stall_o drops in the same cycle (combinational mask).
  - valid_o is not asserted and result_o is unchanged.
  - annul_i together with start_i in IDLE: no start.
- Reset mid-BUSY: immediate IDLE, and no valid_o pulse follows.
- Back-to-back divides: the second start is accepted in the IDLE cycle after DONE. No bubble is required beyond DONE.

Decomposition:
- Shared package/header (defines2.vh): the DIV/DIVU ALU control encodings, the IDLE/BUSY/DONE state encodings, and the divider WIDTH constant.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The FSM, counter, sign handling and result register stay in div_iter.

Test Plan:
- DIVU, a=100, b=7, start at cycle 0 -> stall_o high cycles 0..32; valid_o pulse at cycle 33; result_o={32'd2, 32'd14}.
- DIV, a=-100 (0xFFFFFF9C), b=7 -> result_o={0xFFFFFFFE, 0xFFFFFFF2}; also a=100, b=-7 -> {0x00000002, 0xFFFFFFF2}.
- DIV, a=0x80000000, b=0xFFFFFFFF -> result_o={0x00000000, 0x80000000}, no hang; DIVU a=5, b=0 -> {0x00000005, 0xFFFFFFFF} at cycle 33.
- Start, then annul_i=1 at cycle 10 -> stall_o=0 at cycle 10, IDLE at cycle 11, no valid_o; result_o keeps its previous value; the next start completes correctly.
- Reset: rst=0 asserted mid-BUSY (cycle 15) -> asynchronous return to IDLE with outputs zero; no valid_o after release.
- Back-to-back: start held high across DONE (cycle 33) -> exactly one valid_o pulse; new start_i at cycle 34 -> second valid_o at cycle 67 with the correct result.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: ALU control encodings,
// FSM state type and the default operand width.
package div_iter_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [7:0] ALU_CTRL_DIV  = 8'h1a;
  localparam logic [7:0] ALU_CTRL_DIVU = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor holds between steps, so the extra top bit of trial
  // is a clean borrow flag.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    quoNext = {quo[WIDTH-2:0], ~trial[WIDTH]};
    remNext = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative DIV/DIVU unit for the execute stage: stalls the pipe while
// dividing and pulses valid_o with {remainder, quotient} for HI/LO.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] result_o
);

  divState_e        state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, quo, divisor, dividendRaw;
  logic             negQuo, negRem, divByZero, validQ;
  logic [WIDTH-1:0] remNext, quoNext, absA, absB, quoFinal, remFinal;
  logic             negA, negB, lastStep;

  assign negA     = signed_i & a_i[WIDTH-1];
  assign negB     = signed_i & b_i[WIDTH-1];
  assign absA     = negA ? -a_i : a_i;
  assign absB     = negB ? -b_i : b_i;
  assign lastStep = (count == CNT_W'(WIDTH - 1));

  always_comb begin
    quoFinal = negQuo ? -quoNext : quoNext;
    remFinal = negRem ? -remNext : remNext;
  end

  // annul_i masks both handshake outputs combinationally so a flushed
  // divide neither holds the pipe nor writes HI/LO in that same cycle.
  assign stall_o = rst & ~annul_i &
                   (((state == IDLE) & start_i) | (state == BUSY));
  assign valid_o = validQ & ~annul_i;

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .remNext (remNext),
    .quoNext (quoNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      dividendRaw <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      divByZero   <= 1'b0;
      validQ      <= 1'b0;
      result_o    <= '0;
    end else if (annul_i) begin
      state  <= IDLE;
      count  <= '0;
      validQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          validQ <= 1'b0;
          if (start_i) begin
            quo         <= absA;
            rem         <= '0;
            divisor     <= absB;
            dividendRaw <= a_i;
            negQuo      <= negA ^ negB;
            negRem      <= negA;
            divByZero   <= (b_i == '0);
            count       <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          rem   <= remNext;
          quo   <= quoNext;
          count <= count + CNT_W'(1);
          if (lastStep) begin
            state    <= DONE;
            validQ   <= 1'b1;
            result_o <= divByZero ? {dividendRaw, {WIDTH{1'b1}}}
                                  : {remFinal, quoFinal};
          end
        end
        DONE: begin
          // The divide instruction is still in execute here; its start_i
          // must not launch a second operation.
          validQ <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          validQ <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table, random operands against
// a plain-arithmetic model, and annul/reset/back-to-back sequences.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        annul_i = 1'b0;
  logic        stall_o;
  logic        valid_o;
  logic [63:0] result_o;

  int tests = 0;
  int failed = 0;

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Launches one divide and waits (bounded) for valid_o; inputs are
  // scrambled after the start cycle to catch operands not being latched.
  task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output logic stallOk);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
    #3;
    stallOk = (stall_o === 1'b1) && (valid_o === 1'b0);
    lat = -1;
    res = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0; a_i = $urandom; b_i = $urandom; signed_i = ~sgn;
      #3;
      if (valid_o === 1'b1) begin
        lat = c;
        res = result_o;
        if (stall_o !== 1'b0) stallOk = 1'b0;
        break;
      end
      if (stall_o !== 1'b1) stallOk = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] res, prev;
    logic        stallOk, sawValid, sawStall;
    int          lat, nValid;
    int          vCycle[2];
    logic [63:0] vRes[2];

    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14}};
    vecs[1] = '{"div_m100_7",   1'b1, 32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE, 32'hFFFFFFF2}};
    vecs[2] = '{"div_100_m7",   1'b1, 32'd100,       32'hFFFFFFF9,  {32'h00000002, 32'hFFFFFFF2}};
    vecs[3] = '{"div_overflow", 1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h00000000, 32'h80000000}};
    vecs[4] = '{"divu_by_zero", 1'b0, 32'd5,         32'd0,         {32'h00000005, 32'hFFFFFFFF}};
    vecs[5] = '{"div_by_zero",  1'b1, 32'hFFFFFFF0,  32'd0,         {32'hFFFFFFF0, 32'hFFFFFFFF}};
    vecs[6] = '{"divu_big",     1'b0, 32'hFFFFFFFF,  32'h00010000,  {32'h0000FFFF, 32'h0000FFFF}};

    // Reset state, with start_i high to confirm stall_o stays masked.
    start_i = 1'b1;
    #2;
    check("reset_stall",  64'(stall_o), 64'd0);
    check("reset_valid",  64'(valid_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      runDiv(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, stallOk);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
      check({vecs[i].name, "_stall"}, 64'(stallOk), 64'd1);
    end

    // Pulse width and result hold after DONE.
    @(posedge clk); #4;
    check("post_done_valid",  64'(valid_o), 64'd0);
    check("post_done_result", result_o, vecs[6].exp);

    for (int n = 0; n < 24; n++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom % 2);
      a = $urandom;
      case ($urandom % 4)
        0: b = $urandom;
        1: b = $urandom % 16;
        2: b = -($urandom % 16);
        default: b = $urandom >> ($urandom % 32);
      endcase
      runDiv(sgn, a, b, res, lat, stallOk);
      check($sformatf("rand%0d_result", n), res, refDiv(sgn, a, b));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'd33);
    end

    // Annul at cycle 10 of a busy divide.
    prev = result_o;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    annul_i = 1'b1;
    #3;
    check("annul_stall_same_cycle", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    #3;
    check("annul_idle_stall", 64'(stall_o), 64'd0);
    sawValid = 1'b0;
    sawStall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #4;
      if (valid_o !== 1'b0) sawValid = 1'b1;
      if (stall_o !== 1'b0) sawStall = 1'b1;
    end
    check("annul_no_valid", 64'(sawValid), 64'd0);
    check("annul_no_stall", 64'(sawStall), 64'd0);
    check("annul_result_held", result_o, prev);
    runDiv(1'b0, 32'd1000, 32'd3, res, lat, stallOk);
    check("after_annul_result", res, {32'd1, 32'd333});
    check("after_annul_latency", 64'(lat), 64'd33);

    // Asynchronous reset at cycle 15 of a busy divide.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'hFFFFF000; b_i = 32'd17;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("midrst_stall",  64'(stall_o), 64'd0);
    check("midrst_valid",  64'(valid_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    sawValid = 1'b0;
    sawStall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #4;
      if (valid_o !== 1'b0) sawValid = 1'b1;
      if (stall_o !== 1'b0) sawStall = 1'b1;
    end
    check("midrst_no_valid", 64'(sawValid), 64'd0);
    check("midrst_no_stall", 64'(sawStall), 64'd0);

    // Back-to-back: start held through DONE, second operands at cycle 34.
    nValid = 0;
    vCycle[0] = -1; vCycle[1] = -1;
    vRes[0] = '0; vRes[1] = '0;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
    for (int c = 1; c <= 72; c++) begin
      @(posedge clk); #1;
      if (c == 34) begin a_i = 32'd1000; b_i = 32'd9; end
      if (c == 35) start_i = 1'b0;
      #3;
      if (valid_o === 1'b1) begin
        if (nValid < 2) begin
          vCycle[nValid] = c;
          vRes[nValid] = result_o;
        end
        nValid++;
      end
    end
    check("b2b_valid_count", 64'(nValid), 64'd2);
    check("b2b_first_cycle", 64'(vCycle[0]), 64'd33);
    check("b2b_first_result", vRes[0], {32'd2, 32'd14});
    check("b2b_second_cycle", 64'(vCycle[1]), 64'd67);
    check("b2b_second_result", vRes[1], refDiv(1'b0, 32'd1000, 32'd9));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
